// File: rtl/anim_sprite_fetch.sv
// Purpose: maps VGA pixel coordinates to sprite SRAM read addresses and composites the 2x-upscaled animated sprite over the background.
// Latency: rgb_valid is asserted exactly 3 clk after the pixel_tick that produced it, and one pixel per cycle is accepted.
// Backpressure: none; the pipeline never stalls, and the VGA timing and the SRAM keep pace with pixel_tick.
module anim_sprite_fetch #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 12,
   parameter int FRAME_W    = 64,
   parameter int FRAME_H    = 40,
   parameter int NUM_FRAMES = 8,
   parameter int FRAME_HOLD = 6,
   parameter logic [DATA_WIDTH-1:0] KEY_COLOR = 12'h0F0,
   parameter logic [DATA_WIDTH-1:0] BG_COLOR  = 12'h000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pixel_tick,
   input  logic                  video_on,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   input  logic                  frame_start,
   input  logic                  anim_en,
   input  logic [9:0]            pos_x,
   input  logic [9:0]            pos_y,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   input  logic [DATA_WIDTH-1:0] sram_data,
   output logic [DATA_WIDTH-1:0] rgb_out,
   output logic                  rgb_valid
);

   localparam int IW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam logic signed [10:0]      RX_LIM   = 11'(2 * FRAME_W);
   localparam logic signed [10:0]      RY_LIM   = 11'(2 * FRAME_H);
   localparam logic [ADDR_WIDTH-1:0]   FW_A     = ADDR_WIDTH'(FRAME_W);
   localparam logic [ADDR_WIDTH-1:0]   FRAME_SZ = ADDR_WIDTH'(FRAME_W * FRAME_H);
   localparam logic [IW-1:0]           IDX_LAST = IW'(NUM_FRAMES - 1);
   localparam logic [HW-1:0]           HOLD_LAST = HW'(FRAME_HOLD - 1);

   logic [IW-1:0]         frame_idx;
   logic [HW-1:0]         hold_cnt;
   logic [ADDR_WIDTH-1:0] frame_base;

   logic signed [10:0]    rx;
   logic signed [10:0]    ry;
   logic                  in_sprite;
   logic [ADDR_WIDTH-1:0] fetch_addr;

   logic v0, s0, vo0;
   logic v1, s1, vo1;

   assign sram_we = 1'b0;

   // Sprite-relative coordinates, hit test and the stored-pixel address (each stored pixel covers 2x2 screen pixels).
   always_comb begin
      rx         = signed'({1'b0, pixel_x}) - signed'({1'b0, pos_x});
      ry         = signed'({1'b0, pixel_y}) - signed'({1'b0, pos_y});
      in_sprite  = video_on && !rx[10] && (rx < RX_LIM) && !ry[10] && (ry < RY_LIM);
      fetch_addr = frame_base
                 + ADDR_WIDTH'(ry[10:1]) * FW_A
                 + ADDR_WIDTH'(rx[10:1]);
   end

   // Stage 0: issue the SRAM read; the address is held when the pixel misses the sprite.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sram_en   <= 1'b0;
         sram_addr <= '0;
         v0        <= 1'b0;
         s0        <= 1'b0;
         vo0       <= 1'b0;
      end else begin
         v0      <= pixel_tick;
         s0      <= pixel_tick && in_sprite;
         vo0     <= pixel_tick && video_on;
         sram_en <= pixel_tick && in_sprite;
         if (pixel_tick && in_sprite)
            sram_addr <= fetch_addr;
      end
   end

   // Stage 1: flags ride alongside the SRAM read cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v1  <= 1'b0;
         s1  <= 1'b0;
         vo1 <= 1'b0;
      end else begin
         v1  <= v0;
         s1  <= s0;
         vo1 <= vo0;
      end
   end

   // Stage 2: composite against blanking, background and the transparent key; the colour holds between pixels.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rgb_out   <= '0;
         rgb_valid <= 1'b0;
      end else begin
         rgb_valid <= v1;
         if (v1) begin
            if (!vo1)
               rgb_out <= '0;
            else if (!s1 || sram_data == KEY_COLOR)
               rgb_out <= BG_COLOR;
            else
               rgb_out <= sram_data;
         end
      end
   end

   // Animation sequencer: frame_base steps by one frame size per advance, so no multiplier is needed.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_idx  <= '0;
         frame_base <= '0;
         hold_cnt   <= '0;
      end else if (frame_start && anim_en) begin
         if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (frame_idx == IDX_LAST) begin
               frame_idx  <= '0;
               frame_base <= '0;
            end else begin
               frame_idx  <= frame_idx + 1'b1;
               frame_base <= frame_base + FRAME_SZ;
            end
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/anim_sprite_fetch.md
Name: anim_sprite_fetch

Overview:
- Pixel-pipeline stage directly upstream of the initialized image SRAM. It converts VGA pixel coordinates into SRAM read addresses for the current animation frame and consumes the SRAM read data one cycle later.
- It composites a 2x-upscaled sprite over a background colour and advances the animation frame on a programmable count of vertical frames.
- Output goes straight to the VGA RGB register.

Parameters:
- ADDR_WIDTH, 16, SRAM address width.
- DATA_WIDTH, 12, SRAM word width = RGB444 pixel.
- FRAME_W, 64, sprite width in stored pixels.
- FRAME_H, 40, sprite height in stored pixels.
- NUM_FRAMES, 8, animation frames stored back-to-back from address 0.
- FRAME_HOLD, 6, vertical frames each animation frame is shown.
- KEY_COLOR, 12'h0F0, transparent colour.
- BG_COLOR, 12'h000, background colour.

Ports:
- clk  in  1  system/pixel clock, all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- pixel_tick  in  1  one-cycle strobe marking a new pixel.
- video_on  in  1  visible-area flag, qualified by pixel_tick.
- pixel_x  in  10  current column.
- pixel_y  in  10  current row.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- anim_en  in  1  1 = animation advances, 0 = frame frozen.
- pos_x  in  10  sprite top-left column on screen.
- pos_y  in  10  sprite top-left row on screen.
- sram_en  out  1  SRAM enable.
- sram_we  out  1  SRAM write enable, constant 0.
- sram_addr  out  ADDR_WIDTH  SRAM read address.
- sram_data  in  DATA_WIDTH  SRAM read data, valid 1 cycle after address.
- rgb_out  out  DATA_WIDTH  composited pixel.
- rgb_valid  out  1  rgb_out corresponds to a pixel_tick issued 3 cycles earlier.

Behaviour:
- Reset (reset_n=0 at posedge): sram_en=0, sram_addr=0, rgb_out=0, rgb_valid=0, frame_idx=0, frame_base=0, hold_cnt=0, all pipeline valids cleared. sram_we is always 0.
- Stage 0 (register, on pixel_tick):
  - rx = pixel_x - pos_x and ry = pixel_y - pos_y, computed 11-bit signed.
  - in_sprite = video_on & 0<=rx<2*FRAME_W & 0<=ry<2*FRAME_H.
  - sram_addr = frame_base + (ry>>1)*FRAME_W + (rx>>1) when in_sprite, else unchanged.
  - sram_en = in_sprite.
  - Pipeline flags: v0 = pixel_tick; s0 = in_sprite; vo0 = video_on.
- Stage 1 = SRAM read cycle: v1/s1/vo1 are copies of v0/s0/vo0.
- Stage 2 (register):
  - rgb_valid = v1.
  - rgb_out = 0 if !vo1.
  - rgb_out = BG_COLOR if !s1 or sram_data==KEY_COLOR.
  - rgb_out = sram_data otherwise.
- Latency: exactly 3 clk from pixel_tick to rgb_valid. Pipeline is fully pipelined, with no stalls, and accepts pixel_tick every cycle.
- Cycles without pixel_tick: v0=0 and sram_en=0. rgb_out holds its value and rgb_valid=0.
- Animation counter, updated on frame_start:
  - If anim_en=0: nothing changes.
  - If anim_en=1 and hold_cnt==FRAME_HOLD-1: hold_cnt=0, frame_idx advances, and frame_base += FRAME_W*FRAME_H.
  - If anim_en=1 and hold_cnt<FRAME_HOLD-1: hold_cnt++.
- Wrap-around: when frame_idx==NUM_FRAMES-1 advances, frame_idx=0 and frame_base=0. No multiplier is used for frame_base.
- Timing of frame_base changes: a new frame_base applies to addresses computed in cycles after the frame_start edge. frame_start coinciding with pixel_tick uses the old frame_base.
- Clipping: a sprite partially off-screen is clipped naturally. Coordinates beyond 639/479 never match because video_on=0 there.
- pos_x/pos_y are sampled every pixel and may change only during blanking. A mid-frame change yields tearing only, never an out-of-range address.
- Address bound: max address = NUM_FRAMES*FRAME_W*FRAME_H-1, which must be < 2^ADDR_WIDTH. The default is 20479.
- Reset mid-line: the pipeline is flushed and no rgb_valid is produced for in-flight pixels.

Test Plan:
- Reset, then idle 10 cycles -> rgb_out=0, rgb_valid=0, sram_en=0, sram_addr=0.
- pos=(100,50), frame 0, pixel (100,50) tick -> sram_addr=0 next cycle. Pixel (227,129) -> addr=39*64+63=2559. Pixel (228,50) -> sram_en=0, rgb_out=BG_COLOR 3 cycles later.
- SRAM model returns 12'hF00 at addr 0 -> rgb_out=12'hF00 with rgb_valid exactly 3 cycles after pixel_tick. Returning 12'h0F0 -> rgb_out=12'h000.
- anim_en=1, 6 frame_start pulses -> frame_base=2560, and pixel (100,50) yields addr 2560. After 48 pulses -> wraps to frame_base=0. With anim_en=0, 20 pulses -> no change.
- pixel_tick every cycle across a 128-pixel sprite row -> addresses repeat pairwise (0,0,1,1,...,63,63) and 128 consecutive rgb_valid cycles.
- reset_n=0 for one cycle mid-row with pixels in flight -> next 3 cycles rgb_valid=0, frame_idx=0.
